// File: rtl/exu_muldiv_wb_arb_pkg.sv
// Shared types and constants for the mul/div writeback arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//   wb_entry_t  : one buffered result {data, waddr, commit_id}
//   GRANT_*     : encoding of grant_div_o / last_grant
//   arb_state_e : writeback presentation lock state
package exu_wb_pkg;

   localparam int REG_DATA_WIDTH = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int CID_WIDTH      = 4;
   localparam int WB_DEPTH       = 2;

   localparam logic GRANT_MUL = 1'b0;
   localparam logic GRANT_DIV = 1'b1;

   typedef struct packed {
      logic [REG_DATA_WIDTH-1:0] data;
      logic [REG_ADDR_WIDTH-1:0] waddr;
      logic [CID_WIDTH-1:0]      commit_id;
   } wb_entry_t;

   // OPEN: grant may change each cycle. LOCKED: a presented result was
   // refused, so grant and fields are frozen until it is accepted.
   typedef enum logic {
      ARB_OPEN   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/exu_muldiv_wb_arb_if.sv
// Bundle of the mul/div result pushes and the shared writeback port.
// Latency: n/a (wires only).
// Backpressure: src ready per unit, wb_ready_i from the writeback stage.
//   slave  : the arbiter (consumes unit results, produces writeback)
//   master : the units plus writeback stage driving/observing the arbiter
interface exu_muldiv_wb_arb_if
   import exu_wb_pkg::*;
#(
   parameter int DATA_W = REG_DATA_WIDTH,
   parameter int ADDR_W = REG_ADDR_WIDTH,
   parameter int CID_W  = CID_WIDTH
) ();

   logic              flush_i;

   logic              mul_valid_i;
   logic [DATA_W-1:0] mul_result_i;
   logic [ADDR_W-1:0] mul_waddr_i;
   logic [CID_W-1:0]  mul_commit_id_i;
   logic              mul_ready_o;

   logic              div_valid_i;
   logic [DATA_W-1:0] div_result_i;
   logic [ADDR_W-1:0] div_waddr_i;
   logic [CID_W-1:0]  div_commit_id_i;
   logic              div_ready_o;

   logic              wb_ready_i;
   logic              reg_we_o;
   logic [DATA_W-1:0] reg_wdata_o;
   logic [ADDR_W-1:0] reg_waddr_o;
   logic [CID_W-1:0]  commit_id_o;
   logic              grant_div_o;
   logic              idle_o;

   modport slave (
      input  flush_i,
      input  mul_valid_i, mul_result_i, mul_waddr_i, mul_commit_id_i,
      output mul_ready_o,
      input  div_valid_i, div_result_i, div_waddr_i, div_commit_id_i,
      output div_ready_o,
      input  wb_ready_i,
      output reg_we_o, reg_wdata_o, reg_waddr_o, commit_id_o,
      output grant_div_o, idle_o
   );

   modport master (
      output flush_i,
      output mul_valid_i, mul_result_i, mul_waddr_i, mul_commit_id_i,
      input  mul_ready_o,
      output div_valid_i, div_result_i, div_waddr_i, div_commit_id_i,
      input  div_ready_o,
      output wb_ready_i,
      input  reg_we_o, reg_wdata_o, reg_waddr_o, commit_id_o,
      input  grant_div_o, idle_o
   );

endinterface

// File: rtl/exu_muldiv_wb_arb_fifo.sv
// Small result FIFO of wb_entry_t with synchronous reset and flush.
// Latency: entry pushed at edge N is visible on head_dat after edge N.
// Backpressure: push ignored when full (even with a same-cycle pop) or flushing.
//   push/push_dat : write at tail when not full
//   pop           : remove head when not empty
//   flush         : drop all entries, same-cycle push dropped
//   full/empty/head_dat : status and current head entry
module wb_fifo
   import exu_wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      flush,
   input  logic      push,
   input  wb_entry_t push_dat,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wb_entry_t head_dat
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign push_ok  = push && !full && !flush;
   assign pop_ok   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   // Storage carries no reset; count/pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so pointer increment wraps naturally.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/exu_muldiv_wb_arb.sv
// Buffers mul and div results and round-robins them onto one writeback port.
// Latency: result pushed at edge N is presented in cycle N+1 at the earliest.
// Backpressure: per-source ready = FIFO not full; refused result is held locked.
//   clk, rst_n : clock, synchronous active-low reset
//   bus.slave  : mul/div push groups, flush_i, writeback port, idle_o
module exu_muldiv_wb_arb
   import exu_wb_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH
) (
   input logic                clk,
   input logic                rst_n,
   exu_muldiv_wb_arb_if.slave bus
);

   wb_entry_t  mul_push_dat;
   wb_entry_t  div_push_dat;
   wb_entry_t  mul_head;
   wb_entry_t  div_head;
   wb_entry_t  sel_head;
   logic       mul_full, mul_empty;
   logic       div_full, div_empty;
   logic       mul_pop, div_pop;
   logic       reg_we;
   logic       wb_fire;
   logic       grant;
   logic       grant_q;
   logic       last_grant_q;
   arb_state_e state_q, state_d;

   assign mul_push_dat = '{data: bus.mul_result_i, waddr: bus.mul_waddr_i,
                           commit_id: bus.mul_commit_id_i};
   assign div_push_dat = '{data: bus.div_result_i, waddr: bus.div_waddr_i,
                           commit_id: bus.div_commit_id_i};

   wb_fifo #(.DEPTH(DEPTH)) u_mul_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush_i),
      .push     (bus.mul_valid_i),
      .push_dat (mul_push_dat),
      .pop      (mul_pop),
      .full     (mul_full),
      .empty    (mul_empty),
      .head_dat (mul_head)
   );

   wb_fifo #(.DEPTH(DEPTH)) u_div_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (bus.flush_i),
      .push     (bus.div_valid_i),
      .push_dat (div_push_dat),
      .pop      (div_pop),
      .full     (div_full),
      .empty    (div_empty),
      .head_dat (div_head)
   );

   assign wb_fire = reg_we && bus.wb_ready_i;
   assign mul_pop = wb_fire && (grant == GRANT_MUL);
   assign div_pop = wb_fire && (grant == GRANT_DIV);

   // Lock state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ARB_OPEN;
      end else begin
         state_q <= state_d;
      end
   end

   // Lock next state: enter on a refused presentation, leave on acceptance.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_OPEN:   if (reg_we && !bus.wb_ready_i) state_d = ARB_LOCKED;
         ARB_LOCKED: if (bus.wb_ready_i)            state_d = ARB_OPEN;
         default:    state_d = ARB_OPEN;
      endcase
      if (bus.flush_i) begin
         state_d = ARB_OPEN;
      end
   end

   // Grant selection. While locked the granted FIFO cannot pop, so its head
   // (and therefore every presented field) is stable without extra storage.
   always_comb begin
      grant = GRANT_MUL;
      if (state_q == ARB_LOCKED) begin
         grant = grant_q;
      end else if (!mul_empty && !div_empty) begin
         grant = (last_grant_q == GRANT_DIV) ? GRANT_MUL : GRANT_DIV;
      end else if (!div_empty) begin
         grant = GRANT_DIV;
      end
      reg_we   = (grant == GRANT_DIV) ? !div_empty : !mul_empty;
      sel_head = (grant == GRANT_DIV) ? div_head : mul_head;
      if (!reg_we) begin
         sel_head = '0;
      end
   end

   // grant_q only matters in LOCKED; it captures the grant of the refusing cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         grant_q      <= GRANT_MUL;
         last_grant_q <= GRANT_DIV;
      end else begin
         grant_q <= grant;
         if (bus.flush_i) begin
            last_grant_q <= GRANT_DIV;
         end else if (wb_fire) begin
            last_grant_q <= grant;
         end
      end
   end

   // Ready stays high through a flush since the FIFOs are being emptied.
   assign bus.mul_ready_o = rst_n && (bus.flush_i || !mul_full);
   assign bus.div_ready_o = rst_n && (bus.flush_i || !div_full);
   assign bus.reg_we_o    = reg_we;
   assign bus.reg_wdata_o = sel_head.data;
   assign bus.reg_waddr_o = sel_head.waddr;
   assign bus.commit_id_o = sel_head.commit_id;
   assign bus.grant_div_o = reg_we && (grant == GRANT_DIV);
   assign bus.idle_o      = mul_empty && div_empty;

endmodule

// File: doc/exu_muldiv_wb_arb.md
# exu_muldiv_wb_arb

Writeback arbiter and result buffer between the multiplier and divider result outputs and the single shared EXU writeback port. Each unit pushes finished results (data, rd, commit_id) into its own 2-entry FIFO through a valid/ready handshake, so neither unit stalls on a busy writeback port. A fair round-robin arbiter presents one buffered result at a time to the writeback stage and holds it until accepted. A flush input discards all buffered results on interrupt or pipeline flush.

## Interface
- DATA_W, `REG_DATA_WIDTH: result width
- ADDR_W, `REG_ADDR_WIDTH: destination register address width
- CID_W, 4: commit_id width
- DEPTH, 2: entries per source FIFO; power of two, ≥2
- clk  in  1  clock. One clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset
- flush_i  in  1  discard all buffered results
- mul_valid_i  in  1  multiplier result valid
- mul_result_i  in  DATA_W  multiplier result
- mul_waddr_i  in  ADDR_W  multiplier rd
- mul_commit_id_i  in  CID_W  multiplier commit_id
- mul_ready_o  out  1  mul FIFO can accept a result
- div_valid_i, div_result_i, div_waddr_i, div_commit_id_i, div_ready_o: same as the mul group, for the divider
- wb_ready_i  in  1  writeback stage accepts the presented result
- reg_we_o  out  1  result valid toward writeback
- reg_wdata_o  out  DATA_W  presented data
- reg_waddr_o  out  ADDR_W  presented rd
- commit_id_o  out  CID_W  presented commit_id
- grant_div_o  out  1  0 = presented result is from mul, 1 = from div
- idle_o  out  1  both FIFOs empty

## Operation
- Push: src_valid_i && src_ready_o writes {result, waddr, commit_id} at the tail of that source's FIFO.
- src_ready_o = !full. Push into a full FIFO is never accepted, even if a pop happens in the same cycle.
- Pop: reg_we_o && wb_ready_i removes the head of the granted FIFO.
- A push and a pop on the same FIFO in the same cycle are both performed; the count is unchanged.
- Arbitration:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: the source not accepted most recently is granted.
  - last_grant resets to DIV, so mul wins the first tie.
  - last_grant updates only on a pop.
- Grant lock: once reg_we_o is high and wb_ready_i is low, grant_div_o and all output fields hold, even if the other FIFO becomes non-empty. The lock releases on the accepting cycle.
- reg_we_o = granted FIFO non-empty. When reg_we_o is 0, data/addr/commit_id outputs are 0.
- flush_i (highest priority):
  - Empties both FIFOs.
  - Pushes in the same cycle are dropped; a pop in that cycle completes, since wb_ready_i was seen.
  - Clears the lock and resets last_grant to DIV.
  - src_ready_o stays 1 during flush.
- No bypass: results are never forwarded combinationally from input to output.

## Timing
- Reset (rst_n=0 at posedge):
  - FIFOs empty, lock clear, last_grant = DIV.
  - After reset: reg_we_o=0, reg_wdata_o/reg_waddr_o/commit_id_o=0, grant_div_o=0, idle_o=1.
- src_ready_o is forced to 0 while rst_n=0, and is 1 in the first cycle after reset.
- Latency: a result pushed at edge N appears on reg_we_o in cycle N+1 (after that edge) at the earliest.
- Throughput: one writeback per cycle with wb_ready_i held high. Each source sustains one push per cycle while the FIFO is being drained.
- Pointers wrap modulo DEPTH. The count is DEPTH+1 states wide (0..DEPTH).
- Reset mid-operation: all entries are lost, with no partial writeback.

## Structure
- Shared package exu_wb_pkg:
  - typedef wb_entry_t = packed struct {data, waddr, commit_id}.
  - Constants GRANT_MUL=1'b0, GRANT_DIV=1'b1.
- One sub-module, wb_fifo: parameterized DEPTH × wb_entry_t, sync reset, flush input, push/pop/full/empty/head.
- Instantiated twice. Arbitration, lock and last_grant live in the top module.

## Test plan
- Reset, then push mul {0x0000_0011, rd=5, cid=3} at edge 1 with wb_ready_i=1 → reg_we_o=1 in cycle 2 with rd=5, cid=3, grant_div_o=0; idle_o=1 in cycle 3.
- Mul and div push in the same cycle with wb_ready_i=1 → mul written first, div in the next cycle. Repeat with both FIFOs full → alternates mul, div, mul, div.
- wb_ready_i=0 while only div is presented, then push mul → grant_div_o stays 1 and outputs stay stable until wb_ready_i=1; mul is presented the cycle after.
- Push 2 mul results with wb_ready_i=0 → mul_ready_o=0. A third mul_valid_i is not accepted; after one pop, mul_ready_o=1.
- Fill both FIFOs, assert flush_i with a simultaneous div push → next cycle reg_we_o=0, idle_o=1, and the pushed div result never appears.
- Assert rst_n=0 for one cycle with both FIFOs holding entries → all outputs at reset values; no stale result is presented afterwards.
